// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FILL = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment restarts the count at one so that match is not lost.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? CNT_W'(1) : '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlapping / non-overlapping detection, input-valid qualification,
// registered match pulse and saturating match counter.
// Optional per-cycle trace output is enabled by defining SEQ_DET_TRACE_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             i,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             clr_count,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_o
);

    localparam int             FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

    state_t           state;
    state_t           stateNext;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] histNext;
    logic [PAT_W-1:0] pattern_q;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fillNext;
    logic             overlap_q;
    logic             shiftEn;
    logic             match;

    // Candidate history/fill after accepting the current bit, the match
    // decision, and the next FSM state (cfg_load overrides everything).
    always_comb begin
        histNext  = {hist[PAT_W-2:0], i};
        fillNext  = (fill == FILL_FULL) ? fill : fill + 1'b1;
        shiftEn   = ((state == S_FILL) || (state == S_RUN)) && in_valid && !cfg_load;
        match     = shiftEn && (histNext == pattern_q) && (fillNext == FILL_FULL);
        stateNext = state;
        if (cfg_load) begin
            stateNext = S_FILL;
        end else begin
            case (state)
                S_IDLE: stateNext = S_IDLE;
                S_FILL, S_RUN: begin
                    if (shiftEn) begin
                        if (match && !overlap_q) begin
                            stateNext = S_FILL;
                        end else if (fillNext == FILL_FULL) begin
                            stateNext = S_RUN;
                        end
                    end
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // Detector FSM: configuration latch, history shift, fill tracking and
    // the registered match pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            hist      <= '0;
            fill      <= '0;
            pattern_q <= '0;
            overlap_q <= 1'b1;
            out       <= 1'b0;
        end else begin
            state <= stateNext;
            out   <= match;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
                hist      <= '0;
                fill      <= '0;
            end else if (shiftEn) begin
                hist <= histNext;
                fill <= (match && !overlap_q) ? '0 : fillNext;
            end
        end
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (clr_count),
        .q     (match_count)
    );

    assign state_o = state;

`ifdef SEQ_DET_TRACE_EN
    logic [CNT_W-1:0] traceCount;
    assign traceCount = clr_count ? CNT_W'(1) :
                        ((match_count == '1) ? match_count : match_count + 1'b1);

    // Print the per-edge trace and the post-increment count on each match.
    always @(posedge clock) begin
        $display("%b%b%b_%b%b", state_o, i, in_valid, stateNext, out);
        if (match && !reset) begin
            $display("MATCH %0d", traceCount);
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (PAT_W = 4, CNT_W = 2): directed
// scenarios followed by a randomized run, all checked against a queue-based
// reference model.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             i;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             clr_count;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       state_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               mLoaded  = 1'b0;
    logic [PAT_W-1:0] mPat     = '0;
    bit               mOvl     = 1'b1;
    bit               mBits[$];
    int               mCount   = 0;
    logic             mOut     = 1'b0;
    logic [1:0]       mState   = 2'b00;

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .i           (i),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .out         (out),
        .match_count (match_count),
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the last PAT_W accepted bits since (re)start, compared with the pattern.
    task automatic modelStep(input logic rst, input logic vld, input logic bitIn,
                             input logic ld, input logic [PAT_W-1:0] pat,
                             input logic ovl, input logic clr);
        bit               hit;
        logic [PAT_W-1:0] val;
        hit = 1'b0;
        if (rst) begin
            mLoaded = 1'b0;
            mPat    = '0;
            mOvl    = 1'b1;
            mBits.delete();
            mCount  = 0;
        end else begin
            if (ld) begin
                mLoaded = 1'b1;
                mPat    = pat;
                mOvl    = ovl;
                mBits.delete();
            end else if (mLoaded && vld) begin
                mBits.push_back(bitIn);
                if (mBits.size() > PAT_W) void'(mBits.pop_front());
                if (mBits.size() == PAT_W) begin
                    val = '0;
                    for (int k = 0; k < PAT_W; k++) val = {val[PAT_W-2:0], mBits[k]};
                    hit = (val == mPat);
                end
                if (hit && !mOvl) mBits.delete();
            end
            if (clr) mCount = hit ? 1 : 0;
            else if (hit && mCount < CNT_MAX) mCount++;
        end
        mOut   = hit;
        mState = !mLoaded ? 2'b00 : ((mBits.size() >= PAT_W) ? 2'b10 : 2'b01);
    endtask

    // Drive one cycle of inputs, advance the model, and check after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic vld,
                                 input logic bitIn, input logic ld,
                                 input logic [PAT_W-1:0] pat, input logic ovl,
                                 input logic clr);
        reset       = rst;
        in_valid    = vld;
        i           = bitIn;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        clr_count   = clr;
        modelStep(rst, vld, bitIn, ld, pat, ovl, clr);
        @(posedge clock);
        #1;
        checkOutput({tag, ".out"},   32'(out),         32'(mOut));
        checkOutput({tag, ".count"}, 32'(match_count), 32'(mCount));
        checkOutput({tag, ".state"}, 32'(state_o),     32'(mState));
    endtask

    task automatic feedBits(input string tag, input logic [15:0] bits, input int n);
        for (int b = n - 1; b >= 0; b--) applyStimulus(tag, 1'b0, 1'b1, bits[b], 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic doLoad(input string tag, input logic [PAT_W-1:0] pat, input logic ovl);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b1, pat, ovl, 1'b0);
    endtask

    initial begin
        logic       rRst, rVld, rBit, rLd, rOvl, rClr;
        logic [3:0] rPat;
        int         r;

        // Reset state
        doReset("reset0");
        doReset("reset1");
        checkOutput("reset.exact_state", 32'(state_o), 32'd0);

        // 1: overlap mode, 1011011011
        doLoad("t1.load", 4'b1011, 1'b1);
        feedBits("t1", 16'b10_1101_1011, 10);
        checkOutput("t1.final_count", 32'(match_count), 32'd3);

        // 2: non-overlap mode, same stream (count saturates at 3 with CNT_W=2, so clear first)
        doReset("t2.reset");
        doLoad("t2.load", 4'b1011, 1'b0);
        feedBits("t2", 16'b10_1101_1011, 10);
        checkOutput("t2.final_count", 32'(match_count), 32'd2);

        // 3: in_valid gaps
        doReset("t3.reset");
        doLoad("t3.load", 4'b1011, 1'b1);
        feedBits("t3.a", 16'b10, 2);
        for (int g = 0; g < 3; g++) applyStimulus("t3.gap", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        feedBits("t3.b", 16'b11, 2);
        checkOutput("t3.pulse", 32'(out), 32'd1);

        // 4: pattern 1111, overlap, saturation and clear-with-match
        doReset("t4.reset");
        doLoad("t4.load", 4'b1111, 1'b1);
        feedBits("t4.ones", 16'b11_1111, 6);
        feedBits("t4.sat", 16'b11, 2);
        checkOutput("t4.saturated", 32'(match_count), 32'd3);
        applyStimulus("t4.clrhit", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("t4.clr_with_match", 32'(match_count), 32'd1);

        // 5: partial stream, reload with 0000
        doReset("t5.reset");
        doLoad("t5.load", 4'b1011, 1'b1);
        feedBits("t5.pre", 16'b101, 3);
        doLoad("t5.reload", 4'b0000, 1'b1);
        feedBits("t5.zeros", 16'b000, 3);
        feedBits("t5.fourth", 16'b0, 1);
        checkOutput("t5.pulse", 32'(out), 32'd1);

        // 6: reset mid-stream loses pattern
        doReset("t6.reset");
        doLoad("t6.load", 4'b1011, 1'b1);
        feedBits("t6.pre", 16'b101, 3);
        doReset("t6.midreset");
        feedBits("t6.post", 16'b1011, 4);
        checkOutput("t6.idle", 32'(state_o), 32'd0);

        // Randomized run
        for (int n = 0; n < 600; n++) begin
            r    = $urandom_range(0, 99);
            rRst = (r < 2);
            rLd  = (r >= 2 && r < 8);
            rVld = ($urandom_range(0, 3) != 0);
            rBit = 1'($urandom_range(0, 1));
            rPat = (r < 4) ? 4'b1111 : 4'($urandom);
            rOvl = 1'($urandom_range(0, 1));
            rClr = ($urandom_range(0, 19) == 0);
            applyStimulus("rand", rRst, rVld, rBit, rLd, rPat, rOvl, rClr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
